move_commit: RTL and testbench

//  Upstream stage of build_board: turns one accepted move (from-square, to-square) into the

---
 rtl/chess_pkg.sv | 83 ++++++++
 rtl/move_commit_if.sv | 26 ++
 rtl/square_mux.sv | 13 +
 rtl/move_commit.sv | 131 +++++++++++++
 tb/tb_move_commit.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/chess_pkg.sv
// Shared chess definitions: piece encoding, square helpers, changePiece
// field layout, move_commit FSM encoding and the registered output bundle.
package chess_pkg;

   // Piece colour (bit 3 of a piece code)
   localparam logic WHITE = 1'b0;
   localparam logic BLACK = 1'b1;

   // Piece type (bits 2:0 of a piece code)
   localparam logic [2:0] EMPTY  = 3'b000;
   localparam logic [2:0] KING   = 3'b001;
   localparam logic [2:0] QUEEN  = 3'b010;
   localparam logic [2:0] BISHOP = 3'b011;
   localparam logic [2:0] KNIGHT = 3'b100;
   localparam logic [2:0] ROOK   = 3'b101;
   localparam logic [2:0] PAWN   = 3'b110;

   typedef logic [3:0] piece_t;   // {colour, type}
   typedef logic [5:0] square_t;  // {col[2:0], row[2:0]}, row 0 = top

   // changePiece field layout, shared with build_board
   localparam int CP_WIDTH     = 11;
   localparam int CP_STROBE    = 10;
   localparam int CP_PIECE_LSB = 6;
   localparam int CP_SQ_LSB    = 0;

   // move_commit FSM encoding
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_REJECT = 3'd2;
   localparam logic [2:0] ST_WR_DST = 3'd3;
   localparam logic [2:0] ST_WR_SRC = 3'd4;
   localparam logic [2:0] ST_SETTLE = 3'd5;
   localparam logic [2:0] ST_DONE   = 3'd6;

   // Everything move_commit drives towards build_board and game control
   typedef struct packed {
      logic [CP_WIDTH-1:0] change_piece;
      logic                done;
      logic                capture_flag;
      piece_t              captured;
      logic                err;
   } commit_out_t;

   function automatic logic [2:0] sq_col(input square_t sq);
      return sq[5:3];
   endfunction

   function automatic logic [2:0] sq_row(input square_t sq);
      return sq[2:0];
   endfunction

   function automatic logic piece_colour(input piece_t p);
      return p[3];
   endfunction

   function automatic logic [2:0] piece_type(input piece_t p);
      return p[2:0];
   endfunction

   // A pawn reaching the far rank for its colour becomes a queen
   function automatic piece_t promote(input piece_t p, input square_t to);
      piece_t res;
      res = p;
      if (p == {WHITE, PAWN} && sq_row(to) == 3'd0)
         res = {WHITE, QUEEN};
      else if (p == {BLACK, PAWN} && sq_row(to) == 3'd7)
         res = {BLACK, QUEEN};
      return res;
   endfunction

   // Pack one single-square write command
   function automatic logic [CP_WIDTH-1:0] cp_word(input logic strobe, input piece_t p,
                                                   input square_t sq);
      logic [CP_WIDTH-1:0] w;
      w                   = '0;
      w[CP_STROBE]        = strobe;
      w[CP_PIECE_LSB +: 4] = p;
      w[CP_SQ_LSB +: 6]   = sq;
      return w;
   endfunction

endpackage

// File: rtl/move_commit_if.sv
// Move request handshake plus the commit/report bus of move_commit.
// master = requester / consumer side, slave = move_commit.
interface move_commit_if;
   import chess_pkg::*;

   logic                move_valid;
   square_t             move_from;
   square_t             move_to;
   logic                move_ready;
   logic [CP_WIDTH-1:0] changePiece;
   logic                move_done;
   logic                capture_flag;
   piece_t              captured;
   logic                move_err;

   modport master (
      output move_valid, move_from, move_to,
      input  move_ready, changePiece, move_done, capture_flag, captured, move_err
   );

   modport slave (
      input  move_valid, move_from, move_to,
      output move_ready, changePiece, move_done, capture_flag, captured, move_err
   );

endinterface

// File: rtl/square_mux.sv
// Selects the 4-bit piece code of one square out of the 256-bit board image.
module square_mux
   import chess_pkg::*;
(
   input  logic [255:0] board,
   input  square_t      sq,
   output piece_t       piece
);

   // Square s occupies bits [4s+3:4s]
   assign piece = board[{sq, 2'b00} +: 4];

endmodule

// File: rtl/move_commit.sv
// Turns one accepted move into a destination write and a source clear on
// changePiece, waits for the board to settle, then reports done/capture or
// rejection. Outputs are registered one cycle behind the FSM state.
module move_commit
   import chess_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1
)
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic [2:0]   currentState,
   input  logic [255:0] board,
   move_commit_if.slave mc
);

   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

   logic [2:0]       state;
   logic [2:0]       state_nxt;
   square_t          from_q;
   square_t          to_q;
   piece_t           src_q;
   piece_t           dst_q;
   piece_t           src_rd;
   piece_t           dst_rd;
   logic [CNT_W-1:0] settle_cnt;
   commit_out_t      out_q;
   commit_out_t      out_nxt;
   logic             setup;
   logic             accept;
   logic             reject;

   assign setup  = (currentState == 3'b000);
   assign accept = mc.move_valid && mc.move_ready;

   // The only combinational output; held low while reset is asserted
   assign mc.move_ready = rst_n && (state == ST_IDLE) && !setup;

   square_mux u_src_mux (
      .board (board),
      .sq    (from_q),
      .piece (src_rd)
   );

   square_mux u_dst_mux (
      .board (board),
      .sq    (to_q),
      .piece (dst_rd)
   );

   // Illegal: empty source, null move, or landing on an own piece
   assign reject = (piece_type(src_rd) == EMPTY)
                || (from_q == to_q)
                || ((piece_type(dst_rd) != EMPTY)
                    && (piece_colour(dst_rd) == piece_colour(src_rd)));

   // Next-state logic; board setup overrides every transition
   always_comb begin
      // NOTE: default first so every path assigns state_nxt and no latch is inferred.
      state_nxt = state;
      case (state)
         ST_IDLE:   if (accept) state_nxt = ST_FETCH;
         ST_FETCH:  state_nxt = reject ? ST_REJECT : ST_WR_DST;
         ST_REJECT: state_nxt = ST_IDLE;
         ST_WR_DST: state_nxt = ST_WR_SRC;
         ST_WR_SRC: state_nxt = ST_SETTLE;
         ST_SETTLE: if (settle_cnt == '0) state_nxt = ST_DONE;
         ST_DONE:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
      if (setup)
         state_nxt = ST_IDLE;
   end

   // Output word for the next cycle, derived from the current state
   always_comb begin
      out_nxt = '0;
      if (!setup) begin
         case (state)
            ST_WR_DST: out_nxt.change_piece = cp_word(1'b1, promote(src_q, to_q), to_q);
            ST_WR_SRC: out_nxt.change_piece = cp_word(1'b1, {WHITE, EMPTY}, from_q);
            ST_REJECT: out_nxt.err = 1'b1;
            ST_DONE: begin
               out_nxt.done         = 1'b1;
               out_nxt.captured     = dst_q;
               out_nxt.capture_flag = (piece_type(dst_q) != EMPTY);
            end
            default: ;
         endcase
      end
   end

   // State, latched move, fetched pieces, settle counter and output register
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: every register here has a defined reset value; none of this is memory.
      if (!rst_n) begin
         state      <= ST_IDLE;
         from_q     <= '0;
         to_q       <= '0;
         src_q      <= '0;
         dst_q      <= '0;
         settle_cnt <= '0;
         out_q      <= '0;
      end else begin
         // NOTE: non-blocking so all registers update from pre-edge values.
         state <= state_nxt;
         out_q <= out_nxt;
         if (accept) begin
            from_q <= mc.move_from;
            to_q   <= mc.move_to;
         end
         if (state == ST_FETCH) begin
            src_q <= src_rd;
            dst_q <= dst_rd;
         end
         if (state == ST_WR_SRC)
            settle_cnt <= SETTLE_LAST;
         else if (state == ST_SETTLE && settle_cnt != '0)
            settle_cnt <= settle_cnt - 1'b1;
      end
   end

   assign mc.changePiece  = out_q.change_piece;
   assign mc.move_done    = out_q.done;
   assign mc.capture_flag = out_q.capture_flag;
   assign mc.captured     = out_q.captured;
   assign mc.move_err     = out_q.err;

endmodule

// File: tb/tb_move_commit.sv
// Directed bench for move_commit: normal move, capture, rejects, promotion,
// setup abort, async reset mid-write and a longer settle time.
module tb_move_commit;

   logic         clk;
   logic         rst_n;
   logic [2:0]   current_state;
   logic [255:0] board;
   int           compared;
   int           mismatched;

   move_commit_if m ();
   move_commit_if m3 ();

   move_commit #(.SETTLE_CYCLES(1)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .currentState (current_state),
      .board        (board),
      .mc           (m)
   );

   move_commit #(.SETTLE_CYCLES(3)) dut3 (
      .clk          (clk),
      .rst_n        (rst_n),
      .currentState (current_state),
      .board        (board),
      .mc           (m3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input int sq, input logic [3:0] p);
      board[4*sq +: 4] = p;
   endtask

   function automatic logic [2:0] back_piece(input int c);
      case (c)
         0, 7:    return 3'b101;
         1, 6:    return 3'b100;
         2, 5:    return 3'b011;
         3:       return 3'b010;
         default: return 3'b001;
      endcase
   endfunction

   // Standard start position: black on rows 0/1, white on rows 6/7
   task automatic init_board();
      board = '0;
      for (int c = 0; c < 8; c++) begin
         put(c*8 + 0, {1'b1, back_piece(c)});
         put(c*8 + 1, 4'b1110);
         put(c*8 + 6, 4'b0110);
         put(c*8 + 7, {1'b0, back_piece(c)});
      end
   endtask

   task automatic check_quiet(input string tag);
      check($sformatf("%s cp", tag),   32'(m.changePiece), 32'h0);
      check($sformatf("%s done", tag), 32'(m.move_done), 32'h0);
      check($sformatf("%s err", tag),  32'(m.move_err), 32'h0);
   endtask

   task automatic run_move(input string tag, input logic [5:0] from, input logic [5:0] to,
                           input logic [10:0] exp_dst, input logic [10:0] exp_src,
                           input logic [3:0] exp_cap, input logic exp_flag);
      check($sformatf("%s ready", tag), 32'(m.move_ready), 32'h1);
      m.move_valid = 1'b1;
      m.move_from  = from;
      m.move_to    = to;
      tick();                                   // edge N
      m.move_valid = 1'b0;
      m.move_from  = '0;
      m.move_to    = '0;
      check($sformatf("%s busy", tag), 32'(m.move_ready), 32'h0);
      tick();                                   // N+1
      check_quiet($sformatf("%s n1", tag));
      tick();                                   // N+2
      check($sformatf("%s dst_wr", tag), 32'(m.changePiece), 32'(exp_dst));
      tick();                                   // N+3
      check($sformatf("%s src_clr", tag), 32'(m.changePiece), 32'(exp_src));
      tick();                                   // N+4 settle
      check_quiet($sformatf("%s settle", tag));
      tick();                                   // N+5
      check($sformatf("%s done", tag),     32'(m.move_done), 32'h1);
      check($sformatf("%s captured", tag), 32'(m.captured), 32'(exp_cap));
      check($sformatf("%s cap_flag", tag), 32'(m.capture_flag), 32'(exp_flag));
      check($sformatf("%s cp_idle", tag),  32'(m.changePiece), 32'h0);
      check($sformatf("%s ready_back", tag), 32'(m.move_ready), 32'h1);
      tick();
      check($sformatf("%s done_end", tag), 32'(m.move_done), 32'h0);
      check($sformatf("%s cap_end", tag),  32'(m.captured), 32'h0);
      check($sformatf("%s flag_end", tag), 32'(m.capture_flag), 32'h0);
   endtask

   task automatic run_reject(input string tag, input logic [5:0] from, input logic [5:0] to);
      check($sformatf("%s ready", tag), 32'(m.move_ready), 32'h1);
      m.move_valid = 1'b1;
      m.move_from  = from;
      m.move_to    = to;
      tick();                                   // edge N
      m.move_valid = 1'b0;
      tick();                                   // N+1
      check_quiet($sformatf("%s n1", tag));
      tick();                                   // N+2
      check($sformatf("%s err", tag),   32'(m.move_err), 32'h1);
      check($sformatf("%s cp", tag),    32'(m.changePiece), 32'h0);
      check($sformatf("%s done", tag),  32'(m.move_done), 32'h0);
      check($sformatf("%s ready", tag), 32'(m.move_ready), 32'h1);
      tick();                                   // N+3
      check_quiet($sformatf("%s n3", tag));
   endtask

   initial begin
      compared      = 0;
      mismatched    = 0;
      rst_n         = 1'b0;
      current_state = 3'b000;
      m.move_valid  = 1'b0;
      m.move_from   = '0;
      m.move_to     = '0;
      m3.move_valid = 1'b0;
      m3.move_from  = '0;
      m3.move_to    = '0;
      init_board();

      // Reset state
      #12;
      check_quiet("reset");
      check("reset ready", 32'(m.move_ready), 32'h0);
      check("reset captured", 32'(m.captured), 32'h0);
      rst_n         = 1'b1;
      current_state = 3'b001;
      tick();
      check("post_reset ready", 32'(m.move_ready), 32'h1);

      // 1: white A-pawn 6 -> 4
      run_move("pawn_push", 6'd6, 6'd4, 11'h584, 11'h406, 4'h0, 1'b0);

      // 2: white queen 10 takes black rook 18
      put(10, 4'b0010);
      put(18, 4'b1101);
      run_move("queen_cap", 6'd10, 6'd18, 11'h492, 11'h40A, 4'hD, 1'b1);

      // 3: rejects
      run_reject("rej_empty", 6'd2, 6'd3);
      run_reject("rej_null", 6'd0, 6'd0);
      run_reject("rej_own", 6'd0, 6'd1);

      // 4: promotions (both also capture)
      put(9, 4'b0110);
      run_move("promo_white", 6'd9, 6'd8, 11'h488, 11'h409, 4'hC, 1'b1);
      put(22, 4'b1110);
      run_move("promo_black", 6'd22, 6'd23, 11'h697, 11'h416, 4'h3, 1'b1);

      // 5: setup abort the cycle after acceptance
      check("abort ready", 32'(m.move_ready), 32'h1);
      m.move_valid = 1'b1;
      m.move_from  = 6'd6;
      m.move_to    = 6'd4;
      tick();
      m.move_valid  = 1'b0;
      current_state = 3'b000;
      #1;
      check("abort ready_low", 32'(m.move_ready), 32'h0);
      for (int i = 1; i <= 5; i++) begin
         tick();
         check_quiet($sformatf("abort n%0d", i));
         check($sformatf("abort ready n%0d", i), 32'(m.move_ready), 32'h0);
      end
      current_state = 3'b010;
      #1;
      check("abort ready_back", 32'(m.move_ready), 32'h1);
      tick();
      run_move("abort_recover", 6'd6, 6'd4, 11'h584, 11'h406, 4'h0, 1'b0);

      // 6a: async reset while the destination write is on the bus
      m.move_valid = 1'b1;
      m.move_from  = 6'd6;
      m.move_to    = 6'd4;
      tick();
      m.move_valid = 1'b0;
      tick();
      tick();
      check("rst_mid strobe", 32'(m.changePiece), 32'h584);
      #2;
      rst_n = 1'b0;
      #1;
      check_quiet("rst_mid");
      check("rst_mid ready", 32'(m.move_ready), 32'h0);
      #3;
      rst_n = 1'b1;
      tick();
      check_quiet("rst_after");
      check("rst_after ready", 32'(m.move_ready), 32'h1);

      // 6b: SETTLE_CYCLES=3 instance, move_done exactly at N+7
      check("s3 ready", 32'(m3.move_ready), 32'h1);
      m3.move_valid = 1'b1;
      m3.move_from  = 6'd6;
      m3.move_to    = 6'd4;
      tick();                                   // edge N
      m3.move_valid = 1'b0;
      tick();
      tick();                                   // N+2
      check("s3 dst_wr", 32'(m3.changePiece), 32'h584);
      tick();                                   // N+3
      check("s3 src_clr", 32'(m3.changePiece), 32'h406);
      for (int i = 4; i <= 6; i++) begin
         tick();
         check($sformatf("s3 n%0d cp", i),   32'(m3.changePiece), 32'h0);
         check($sformatf("s3 n%0d done", i), 32'(m3.move_done), 32'h0);
      end
      tick();                                   // N+7
      check("s3 done", 32'(m3.move_done), 32'h1);
      check("s3 flag", 32'(m3.capture_flag), 32'h0);
      tick();
      check("s3 done_end", 32'(m3.move_done), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
